// File: rtl/dcache_fill_ctrl.sv
// D-cache miss/refill controller: stalls on a MEM-stage miss, streams an 8-word block from
// 4-cycle pipelined main memory into the data array, then writes tag+valid. Counters: DCACHE_PERF_CNT_EN.
module dcache_fill_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic [15:0] mem_addr,
  input  logic        hit,
  output logic        stall,
  output logic [15:0] blk_addr,
  output logic        mm_en,
  output logic [15:0] mm_addr,
  input  logic        mm_valid,
  input  logic [15:0] mm_data,
  output logic        fill_we,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        tag_we,
  output logic [15:0] miss_count,
  output logic [15:0] stall_count
);
  // Handshake: mm_en is a request memory always accepts the same cycle; mm_valid is a
  // one-cycle data strobe arriving in request order, with no backpressure in either direction.
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, SETTLE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [3:0]  issue_cnt;
  logic [2:0]  ret_cnt;
  logic        miss;

  // rst gates the only combinational path to stall so every output is 0 during reset.
  assign miss = (state == IDLE) & mem_req & ~hit & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      blk_addr  <= 16'h0000;
      issue_cnt <= 4'd0;
      ret_cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      if (miss) begin
        blk_addr  <= mem_addr & 16'hFFF0;
        issue_cnt <= 4'd0;
        ret_cnt   <= 3'd0;
      end else if (state == FILL) begin
        if (!issue_cnt[3]) issue_cnt <= issue_cnt + 4'd1;
        if (mm_valid)      ret_cnt   <= ret_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mm_en     = 1'b0;
    mm_addr   = 16'h0000;
    fill_we   = 1'b0;
    fill_word = 3'd0;
    fill_data = 16'h0000;
    tag_we    = 1'b0;
    case (state)
      IDLE: begin
        stall = miss;
        if (miss) state_nxt = FILL;
      end
      FILL: begin
        stall = 1'b1;
        mm_en = ~issue_cnt[3];
        if (mm_en) mm_addr = blk_addr | {12'h000, issue_cnt[2:0], 1'b0};
        if (mm_valid) begin
          fill_we   = 1'b1;
          fill_word = ret_cnt;
          fill_data = mm_data;
          // The last word and tag+valid land together; the line is never valid with stale words.
          if (ret_cnt == 3'd7) begin
            tag_we    = 1'b1;
            state_nxt = SETTLE;
          end
        end
      end
      SETTLE: begin
        stall     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [15:0] miss_q, stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_q  <= 16'h0000;
      stall_q <= 16'h0000;
    end else begin
      if (miss && miss_q != 16'hFFFF)   miss_q  <= miss_q + 16'd1;
      if (stall && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  assign miss_count  = miss_q;
  assign stall_count = stall_q;
`else
  assign miss_count  = 16'h0000;
  assign stall_count = 16'h0000;
`endif

endmodule
